// File: rtl/dot_accumulator.sv
// Sequences a multi-cycle multiplier over num_terms operand pairs and sums the
// products into a 16-bit saturating accumulator with a sticky overflow flag.
`default_nettype none

module dot_accumulator #(
    parameter int MUL_START_CYCLES = 4,
    parameter int CNT_W            = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_terms,
    input  logic             in_valid,
    input  logic [15:0]      in_a,
    input  logic [15:0]      in_b,
    output logic             in_ready,
    output logic [15:0]      mul_a,
    output logic [15:0]      mul_b,
    output logic             mul_start,
    input  logic [15:0]      mul_result,
    input  logic             mul_overflow,
    input  logic             mul_finish,
    output logic [15:0]      acc_result,
    output logic             acc_overflow,
    output logic             busy,
    output logic             done
);

    localparam int ISS_W = (MUL_START_CYCLES > 1) ? $clog2(MUL_START_CYCLES) : 1;
    localparam logic [ISS_W-1:0] ISSUE_LAST = ISS_W'(MUL_START_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_ACC,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic [ISS_W-1:0] issue_cnt_q, issue_cnt_d;
    logic             wait_first_q, wait_first_d;
    logic [15:0]      mul_a_q, mul_a_d;
    logic [15:0]      mul_b_q, mul_b_d;
    logic [15:0]      acc_q, acc_d;
    logic             acc_ovf_q, acc_ovf_d;
    logic             in_ready_q, in_ready_d;
    logic             mul_start_q, mul_start_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [16:0]      sum_ext;
    logic             sat_hit;
    logic [15:0]      acc_sat;

    // Sign-extended add; bits 16 and 15 disagree exactly when the 16-bit result overflows.
    always_comb begin
        sum_ext = {acc_q[15], acc_q} + {mul_result[15], mul_result};
        sat_hit = sum_ext[16] ^ sum_ext[15];
        acc_sat = sat_hit ? (sum_ext[16] ? 16'h8000 : 16'h7FFF) : sum_ext[15:0];
    end

    always_comb begin
        // NOTE: every _d starts from its _q so no path through the case leaves a latch.
        state_d      = state_q;
        remaining_d  = remaining_q;
        issue_cnt_d  = issue_cnt_q;
        wait_first_d = wait_first_q;
        mul_a_d      = mul_a_q;
        mul_b_d      = mul_b_q;
        acc_d        = acc_q;
        acc_ovf_d    = acc_ovf_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    remaining_d = num_terms;
                    acc_d       = 16'h0000;
                    acc_ovf_d   = 1'b0;
                    state_d     = (num_terms != '0) ? S_FETCH : S_DONE;
                end
            end
            S_FETCH: begin
                if (in_valid) begin
                    mul_a_d     = in_a;
                    mul_b_d     = in_b;
                    issue_cnt_d = '0;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (issue_cnt_q == ISSUE_LAST) begin
                    issue_cnt_d  = '0;
                    wait_first_d = 1'b1;
                    state_d      = S_WAIT;
                end else begin
                    issue_cnt_d = issue_cnt_q + ISS_W'(1);
                end
            end
            S_WAIT: begin
                // A finish still high from the previous product is not trusted in the first cycle.
                if (wait_first_q) begin
                    wait_first_d = 1'b0;
                end else if (mul_finish) begin
                    state_d = S_ACC;
                end
            end
            S_ACC: begin
                acc_d       = acc_sat;
                acc_ovf_d   = acc_ovf_q | mul_overflow | sat_hit;
                remaining_d = remaining_q - CNT_W'(1);
                state_d     = (remaining_q != CNT_W'(1)) ? S_FETCH : S_DONE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Outputs are registered by decoding the next state.
        in_ready_d  = (state_d == S_FETCH);
        mul_start_d = (state_d == S_ISSUE);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            remaining_q  <= '0;
            issue_cnt_q  <= '0;
            wait_first_q <= 1'b0;
            mul_a_q      <= 16'h0000;
            mul_b_q      <= 16'h0000;
            acc_q        <= 16'h0000;
            acc_ovf_q    <= 1'b0;
            in_ready_q   <= 1'b0;
            mul_start_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            remaining_q  <= remaining_d;
            issue_cnt_q  <= issue_cnt_d;
            wait_first_q <= wait_first_d;
            mul_a_q      <= mul_a_d;
            mul_b_q      <= mul_b_d;
            acc_q        <= acc_d;
            acc_ovf_q    <= acc_ovf_d;
            in_ready_q   <= in_ready_d;
            mul_start_q  <= mul_start_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign in_ready     = in_ready_q;
    assign mul_a        = mul_a_q;
    assign mul_b        = mul_b_q;
    assign mul_start    = mul_start_q;
    assign acc_result   = acc_q;
    assign acc_overflow = acc_ovf_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

`default_nettype wire

// File: tb/tb_dot_accumulator.sv
// Directed bench for dot_accumulator: a scripted multiplier stub answers each
// mul_start burst 10 cycles later and holds finish high until the next burst.
module tb_dot_accumulator;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  num_terms;
    logic        in_valid;
    logic [15:0] in_a;
    logic [15:0] in_b;
    logic        in_ready;
    logic [15:0] mul_a;
    logic [15:0] mul_b;
    logic        mul_start;
    logic [15:0] mul_result;
    logic        mul_overflow;
    logic        mul_finish;
    logic [15:0] acc_result;
    logic        acc_overflow;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_fail   = 0;

    int   tot_ms   = 0;
    int   tot_rise = 0;
    int   tot_done = 0;
    logic ms_seen  = 1'b0;

    logic [15:0] prod [0:255];
    logic        povf [0:255];
    logic [7:0]  term_idx;
    int          dly;
    logic        ms_prev;

    int ms0, rise0, done0;

    dot_accumulator #(
        .MUL_START_CYCLES(4),
        .CNT_W           (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .num_terms   (num_terms),
        .in_valid    (in_valid),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_ready    (in_ready),
        .mul_a       (mul_a),
        .mul_b       (mul_b),
        .mul_start   (mul_start),
        .mul_result  (mul_result),
        .mul_overflow(mul_overflow),
        .mul_finish  (mul_finish),
        .acc_result  (acc_result),
        .acc_overflow(acc_overflow),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    // Multiplier stub: product index restarts whenever a job is accepted.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mul_finish   <= 1'b0;
            mul_result   <= 16'h0000;
            mul_overflow <= 1'b0;
            dly          <= 0;
            term_idx     <= 8'd0;
            ms_prev      <= 1'b0;
        end else begin
            ms_prev <= mul_start;
            if (start && !busy) term_idx <= 8'd0;
            if (mul_start && !ms_prev) begin
                mul_finish <= 1'b0;
                dly        <= 10;
            end else if (dly != 0) begin
                dly <= dly - 1;
                if (dly == 1) begin
                    mul_finish   <= 1'b1;
                    mul_result   <= prod[term_idx];
                    mul_overflow <= povf[term_idx];
                    term_idx     <= term_idx + 8'd1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (mul_start === 1'b1) tot_ms++;
        if (mul_start === 1'b1 && !ms_seen) tot_rise++;
        ms_seen = (mul_start === 1'b1);
        if (done === 1'b1) tot_done++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic snapshot();
        ms0   = tot_ms;
        rise0 = tot_rise;
        done0 = tot_done;
    endtask

    task automatic begin_job(input logic [7:0] n);
        start     = 1'b1;
        num_terms = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int i = 0;
        while (done !== 1'b1 && i < budget) begin
            @(negedge clk);
            i++;
        end
        check({tag, "_done_seen"}, {31'd0, done}, 32'd1);
    endtask

    task automatic set_prods(input int n, input logic [15:0] p0, input logic [15:0] p1,
                             input logic [15:0] p2);
        for (int i = 0; i < 256; i++) begin
            prod[i] = (i == 0) ? p0 : (i == 1) ? p1 : p2;
            povf[i] = 1'b0;
        end
        if (n < 0) $error("bad product count");
    endtask

    initial begin
        rst       = 1'b0;
        start     = 1'b0;
        num_terms = 8'd0;
        in_valid  = 1'b0;
        in_a      = 16'h1234;
        in_b      = 16'hABCD;
        set_prods(3, 16'h0000, 16'h0000, 16'h0000);

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_acc", acc_result, 16'h0000);
        check("rst_ovf", acc_overflow, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", in_ready, 1'b0);
        check("rst_mulstart", mul_start, 1'b0);
        check("rst_done", done, 1'b0);
        rst = 1'b1;
        @(negedge clk);

        // Three terms summing to 0x0600
        set_prods(3, 16'h0100, 16'h0200, 16'h0300);
        in_valid = 1'b1;
        snapshot();
        begin_job(8'd3);
        check("t1_busy", busy, 1'b1);
        check("t1_ready", in_ready, 1'b1);
        @(negedge clk);
        check("t1_mul_a", mul_a, 16'h1234);
        check("t1_mul_b", mul_b, 16'hABCD);
        check("t1_mulstart", mul_start, 1'b1);
        check("t1_ready_low", in_ready, 1'b0);
        wait_done("t1", 500);
        check("t1_acc", acc_result, 16'h0600);
        check("t1_ovf", acc_overflow, 1'b0);
        @(negedge clk);
        check("t1_done_pulse", done, 1'b0);
        check("t1_idle", busy, 1'b0);
        check("t1_hold", acc_result, 16'h0600);
        @(negedge clk);
        check("t1_done_count", tot_done - done0, 1);
        check("t1_ms_cycles", tot_ms - ms0, 12);
        check("t1_ms_rises", tot_rise - rise0, 3);

        // Positive saturation
        set_prods(2, 16'h7000, 16'h2000, 16'h0000);
        begin_job(8'd2);
        wait_done("t2", 500);
        check("t2_acc", acc_result, 16'h7FFF);
        check("t2_ovf", acc_overflow, 1'b1);
        @(negedge clk);

        // Negative saturation
        set_prods(2, 16'h8100, 16'hF000, 16'h0000);
        begin_job(8'd2);
        wait_done("t3", 500);
        check("t3_acc", acc_result, 16'h8000);
        check("t3_ovf", acc_overflow, 1'b1);
        @(negedge clk);

        // Zero-term job finishes immediately and clears the sticky flag
        snapshot();
        begin_job(8'd0);
        check("t4_done", done, 1'b1);
        check("t4_busy", busy, 1'b1);
        check("t4_acc", acc_result, 16'h0000);
        check("t4_ovf", acc_overflow, 1'b0);
        @(negedge clk);
        check("t4_done_clr", done, 1'b0);
        check("t4_idle", busy, 1'b0);
        @(negedge clk);
        check("t4_no_mulstart", tot_ms - ms0, 0);
        check("t4_done_count", tot_done - done0, 1);

        // Multiplier overflow on term 2, operand stall, ignored mid-job start
        set_prods(3, 16'h0010, 16'h0010, 16'h0010);
        povf[1] = 1'b1;
        in_valid = 1'b0;
        snapshot();
        begin_job(8'd3);
        repeat (5) @(negedge clk);
        check("t5_stall_ready", in_ready, 1'b1);
        check("t5_stall_busy", busy, 1'b1);
        check("t5_stall_no_issue", tot_rise - rise0, 0);
        in_valid = 1'b1;
        repeat (8) @(negedge clk);
        start     = 1'b1;
        num_terms = 8'd7;
        @(negedge clk);
        start = 1'b0;
        wait_done("t5", 500);
        check("t5_acc", acc_result, 16'h0030);
        check("t5_ovf", acc_overflow, 1'b1);
        repeat (2) @(negedge clk);
        check("t5_ms_rises", tot_rise - rise0, 3);
        check("t5_done_count", tot_done - done0, 1);

        // Asynchronous reset while waiting on term 2
        set_prods(3, 16'h0011, 16'h0011, 16'h0011);
        snapshot();
        begin_job(8'd3);
        begin
            int i = 0;
            while (!((tot_rise - rise0) == 2 && mul_start === 1'b0) && i < 500) begin
                @(negedge clk);
                i++;
            end
            check("t6_reached_wait", {31'd0, busy}, 32'd1);
        end
        #2 rst = 1'b0;
        #1;
        check("t6_acc", acc_result, 16'h0000);
        check("t6_ovf", acc_overflow, 1'b0);
        check("t6_mul_a", mul_a, 16'h0000);
        check("t6_mul_b", mul_b, 16'h0000);
        check("t6_mulstart", mul_start, 1'b0);
        check("t6_ready", in_ready, 1'b0);
        check("t6_busy", busy, 1'b0);
        check("t6_done", done, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("t6_no_done", tot_done - done0, 0);
        set_prods(1, 16'h0042, 16'h0000, 16'h0000);
        begin_job(8'd1);
        wait_done("t6b", 500);
        check("t6b_acc", acc_result, 16'h0042);
        check("t6b_ovf", acc_overflow, 1'b0);
        @(negedge clk);

        // Maximum term count: 255 unit products
        for (int i = 0; i < 256; i++) begin
            prod[i] = 16'h0001;
            povf[i] = 1'b0;
        end
        snapshot();
        begin_job(8'd255);
        wait_done("t7", 10000);
        check("t7_acc", acc_result, 16'h00FF);
        check("t7_ovf", acc_overflow, 1'b0);
        repeat (2) @(negedge clk);
        check("t7_ms_rises", tot_rise - rise0, 255);
        check("t7_done_count", tot_done - done0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
